// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings for the datapath command sequencer.
// Holds the command-kind codes, the ALU opcode names and the sequencer
// state codes. States are plain 3-bit constants so older code that
// compares raw state values keeps working.
package datapath_pkg;

  // Command kinds presented on cmd_kind
  localparam logic [1:0] KIND_NOP  = 2'b00;
  localparam logic [1:0] KIND_PUSH = 2'b01;
  localparam logic [1:0] KIND_ALU  = 2'b10;
  localparam logic [1:0] KIND_POP  = 2'b11;

  // ALU opcodes forwarded to the datapath unchanged
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_PUSH  = 3'd1;
  localparam state_t S_POP   = 3'd2;
  localparam state_t S_NOP   = 3'd3;
  localparam state_t S_LOAD1 = 3'd4;
  localparam state_t S_LOAD2 = 3'd5;
  localparam state_t S_EXEC  = 3'd6;
  localparam state_t S_ERR   = 3'd7;

endpackage

// File: rtl/stack_depth_tracker.sv
// stack_depth_tracker: saturating up/down occupancy counter that mirrors
// the datapath stack, plus the flags the sequencer needs to judge whether
// a command is legal (full, empty, at least two entries).
module stack_depth_tracker
  import datapath_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] depth,
  output logic         full,
  output logic         empty,
  output logic         has_two
);

  localparam logic [W-1:0] MAX_COUNT = W'(DEPTH);

  logic [W-1:0] count;

  // Count pushes up and pops down, never wrapping past either end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX_COUNT)) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign depth   = count;
  assign full    = (count == MAX_COUNT);
  assign empty   = (count == '0);
  assign has_two = (count >= W'(2));

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: command sequencer for the stack/temp/ALU datapath.
// Accepts one command per valid/ready handshake and expands it into the
// registered push/pop/loadTemp1/loadTemp2 strobes, holding opcode and din.
// Optional feature macro: DATAPATH_CTRL_CHECK_EN enables occupancy
// tracking and rejection of commands that would over/underflow the stack;
// without it err and depth are tied 0 and every command executes.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_kind,
  input  logic [2:0]                   cmd_alu_op,
  input  logic [DW-1:0]                cmd_data,
  output logic                         push,
  output logic                         pop,
  output logic                         loadTemp1,
  output logic                         loadTemp2,
  output logic [2:0]                   opcode,
  output logic [DW-1:0]                din,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  state_t state;
  state_t next_state;
  logic   accept;
  logic   cmd_legal;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef DATAPATH_CTRL_CHECK_EN
  logic full;
  logic empty;
  logic has_two;

  stack_depth_tracker #(
    .DEPTH (DEPTH)
  ) u_depth_tracker (
    .clk     (clk),
    .reset   (reset),
    .inc     (state == S_PUSH),
    .dec     (pop),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .has_two (has_two)
  );

  // Judge the offered command against the current occupancy
  always_comb begin
    cmd_legal = 1'b1;
    case (cmd_kind)
      KIND_PUSH: cmd_legal = !full;
      KIND_POP:  cmd_legal = !empty;
      KIND_ALU:  cmd_legal = has_two;
      default:   cmd_legal = 1'b1;
    endcase
  end
`else
  assign cmd_legal = 1'b1;
  assign depth     = '0;
`endif

  // Pick the next state: dispatch on accept, walk the ALU sequence, else idle
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_legal) begin
            next_state = S_ERR;
          end else begin
            case (cmd_kind)
              KIND_PUSH: next_state = S_PUSH;
              KIND_POP:  next_state = S_POP;
              KIND_ALU:  next_state = S_LOAD1;
              default:   next_state = S_NOP;
            endcase
          end
        end
      end
      S_LOAD1: next_state = S_LOAD2;
      S_LOAD2: next_state = S_EXEC;
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes are registered from the state being entered so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push      <= 1'b0;
      pop       <= 1'b0;
      loadTemp1 <= 1'b0;
      loadTemp2 <= 1'b0;
      done      <= 1'b0;
    end else begin
      push      <= (next_state == S_PUSH);
      pop       <= (next_state == S_POP) || (next_state == S_LOAD1) ||
                   (next_state == S_LOAD2);
      loadTemp1 <= (next_state == S_LOAD1);
      loadTemp2 <= (next_state == S_LOAD2);
      done      <= (next_state == S_PUSH) || (next_state == S_POP) ||
                   (next_state == S_NOP)  || (next_state == S_EXEC);
    end
  end

`ifdef DATAPATH_CTRL_CHECK_EN
  // Rejection pulse, one cycle while in ERR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (next_state == S_ERR);
    end
  end
`else
  assign err = 1'b0;
`endif

  // Capture immediate and opcode only on a legal accept so the ALU result stays stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din    <= '0;
      opcode <= '0;
    end else if (accept && cmd_legal) begin
      if (cmd_kind == KIND_PUSH) begin
        din <= cmd_data;
      end
      if (cmd_kind == KIND_ALU) begin
        opcode <= cmd_alu_op;
      end
    end
  end

endmodule
